// File: rtl/lasso_trace_player.sv
// Replays a stored lasso trace: a finite prefix, then an endlessly repeated loop.
// Drives known lasso witnesses into liveness-to-safety monitors.
module lasso_trace_player #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW:0]      prefix_len,
  input  logic [AW:0]      loop_len,
  input  logic             start,
  input  logic             stop,
  input  logic             trace_ready,
  output logic             trace_valid,
  output logic [WIDTH-1:0] trace_data,
  output logic             loop_start,
  output logic             in_loop,
  output logic [7:0]       lap_count,
  output logic             cfg_err,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, PREFIX, LOOP} state_t;

  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  state_t           state, nxt_state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr, nxt_ptr, loop_first;
  logic [AW:0]      plen, llen;
  logic [AW+1:0]    cfg_sum;
  logic [7:0]       nxt_lap;
  logic             cfg_ok, is_pre_last, is_loop_last;

  // Sum at AW+2 bits so two max-width lengths cannot wrap past the check.
  assign cfg_sum      = {1'b0, prefix_len} + {1'b0, loop_len};
  assign cfg_ok       = (loop_len != '0) && (cfg_sum <= DEPTH_W);
  assign loop_first   = plen[AW-1:0];
  assign is_pre_last  = ({1'b0, ptr} == plen - (AW+1)'(1));
  assign is_loop_last = ({1'b0, ptr} == plen + llen - (AW+1)'(1));
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (wr_en && !stop && state == IDLE) mem[wr_addr] <= wr_data;
  end

  // ptr/state always describe the entry being presented; these give the one after it.
  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr + AW'(1);
    nxt_lap   = lap_count;
    if (state == PREFIX && is_pre_last) begin
      nxt_state = LOOP;
      nxt_ptr   = loop_first;
    end else if (state == LOOP && is_loop_last) begin
      nxt_ptr = loop_first;
      if (lap_count != 8'hFF) nxt_lap = lap_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      plen        <= '0;
      llen        <= '0;
      trace_valid <= 1'b0;
      trace_data  <= '0;
      loop_start  <= 1'b0;
      in_loop     <= 1'b0;
      lap_count   <= '0;
      cfg_err     <= 1'b0;
    end else if (stop) begin
      state       <= IDLE;
      trace_valid <= 1'b0;
      loop_start  <= 1'b0;
      in_loop     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              cfg_err   <= 1'b0;
              plen      <= prefix_len;
              llen      <= loop_len;
              lap_count <= '0;
              ptr       <= '0;
              if (prefix_len == '0) begin
                state   <= LOOP;
                in_loop <= 1'b1;
              end else begin
                state   <= PREFIX;
                in_loop <= 1'b0;
              end
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        default: begin
          if (!trace_valid) begin
            // First fetch after start: ptr is 0 or prefix_len, lap_count is 0.
            trace_valid <= 1'b1;
            trace_data  <= mem[ptr];
            loop_start  <= (state == LOOP);
          end else if (trace_ready) begin
            state      <= nxt_state;
            ptr        <= nxt_ptr;
            lap_count  <= nxt_lap;
            trace_data <= mem[nxt_ptr];
            in_loop    <= (nxt_state == LOOP);
            loop_start <= (nxt_state == LOOP) && (nxt_ptr == loop_first) && (nxt_lap == 8'd0);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lasso_trace_player.sv
// Randomized bench for lasso_trace_player against an index-arithmetic reference model.
module tb_lasso_trace_player;
  localparam int WIDTH = 7;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [AW:0]      prefix_len = '0;
  logic [AW:0]      loop_len = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             trace_ready = 1'b0;
  logic             trace_valid;
  logic [WIDTH-1:0] trace_data;
  logic             loop_start;
  logic             in_loop;
  logic [7:0]       lap_count;
  logic             cfg_err;
  logic             busy;

  always #5 clk = ~clk;

  lasso_trace_player #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prefix_len(prefix_len), .loop_len(loop_len), .start(start), .stop(stop),
    .trace_ready(trace_ready), .trace_valid(trace_valid), .trace_data(trace_data),
    .loop_start(loop_start), .in_loop(in_loop), .lap_count(lap_count),
    .cfg_err(cfg_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the k-th transferred entry of a lasso is fully determined by k, P and L.
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic m_busy = 1'b0, m_valid = 1'b0, m_err = 1'b0;
  int   m_k = 0, m_p = 0, m_l = 1, m_lap_hold = 0;

  function automatic int lap_of(input int k, input int p, input int l);
    if (k < p) return 0;
    return ((k - p) / l > 255) ? 255 : (k - p) / l;
  endfunction

  function automatic int idx_of(input int k, input int p, input int l);
    return (k < p) ? k : p + (k - p) % l;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0;
      m_k <= 0; m_p <= 0; m_l <= 1; m_lap_hold <= 0;
    end else if (stop) begin
      if (m_busy) m_lap_hold <= lap_of(m_k, m_p, m_l);
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else if (!m_busy) begin
      if (wr_en) m_mem[wr_addr] <= wr_data;
      if (start) begin
        if (int'(loop_len) >= 1 && int'(prefix_len) + int'(loop_len) <= DEPTH) begin
          m_busy <= 1'b1; m_valid <= 1'b0; m_k <= 0; m_err <= 1'b0;
          m_p <= int'(prefix_len); m_l <= int'(loop_len);
        end else begin
          m_err <= 1'b1;
        end
      end
    end else if (!m_valid) begin
      m_valid <= 1'b1;
    end else if (trace_ready) begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    int lap;
    if (mon_en) begin
      lap = m_busy ? lap_of(m_k, m_p, m_l) : m_lap_hold;
      chk("busy", busy, m_busy);
      chk("trace_valid", trace_valid, m_valid);
      chk("cfg_err", cfg_err, m_err);
      chk("lap_count", lap_count, lap);
      chk("in_loop", in_loop, m_busy && (m_k >= m_p));
      chk("loop_start", loop_start, m_valid && (m_k == m_p));
      if (m_valid) chk("trace_data", trace_data, m_mem[idx_of(m_k, m_p, m_l)]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = WIDTH'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(input int p, input int l);
    prefix_len = (AW+1)'(p); loop_len = (AW+1)'(l); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  int seq1 [8] = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h12, 'h13};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", trace_valid, 0); chk("rst_data", trace_data, 0);
    chk("rst_busy", busy, 0);         chk("rst_lap", lap_count, 0);
    chk("rst_err", cfg_err, 0);       chk("rst_in_loop", in_loop, 0);

    // Basic lasso 10,11,(12..15)*
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) wr(i, 'h10 + i);
    trace_ready = 1'b1;
    go(2, 4);
    @(negedge clk);
    chk("latency_busy", busy, 1); chk("latency_valid", trace_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("seq1_data", trace_data, seq1[i]);
      chk("seq1_loop_start", loop_start, (i == 2) ? 1 : 0);
      if (i == 5) chk("seq1_lap_before", lap_count, 0);
      if (i == 6) chk("seq1_lap_after", lap_count, 1);
    end

    // stop with start and a write in the same cycle
    @(posedge clk); #1;
    stop = 1'b1; start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 7'h55;
    tick();
    stop = 1'b0; start = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk("stop_valid", trace_valid, 0); chk("stop_busy", busy, 0);
    @(posedge clk); #1;
    go(2, 4);
    @(negedge clk);
    @(negedge clk); chk("restart_data0", trace_data, 'h10);
    @(negedge clk); chk("restart_data1", trace_data, 'h11);
    @(negedge clk); chk("restart_loop_start", loop_start, 1);

    // Backpressure pattern 1,0,0,1
    @(posedge clk); #1;
    halt();
    go(2, 4);
    for (int i = 0; i < 40; i++) begin
      trace_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end

    // Single-entry loop, lap saturation
    trace_ready = 1'b1;
    halt();
    wr(0, 'h7F);
    go(0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("single_data", trace_data, 'h7F);
    chk("single_loop_start", loop_start, 1);
    chk("single_in_loop", in_loop, 1);
    @(posedge clk); #1;
    repeat (260) tick();
    @(negedge clk);
    chk("lap_saturate", lap_count, 255);

    // Rejected configurations
    @(posedge clk); #1;
    halt();
    go(0, 0);
    @(negedge clk); chk("rej_len0_err", cfg_err, 1); chk("rej_len0_busy", busy, 0);
    @(posedge clk); #1;
    go(10, 7);
    @(negedge clk); chk("rej_ovf_err", cfg_err, 1); chk("rej_ovf_busy", busy, 0);
    @(posedge clk); #1;
    go(2, 4);
    @(negedge clk); chk("accept_err", cfg_err, 0); chk("accept_busy", busy, 1);

    // Reset asserted between edges mid-loop
    @(posedge clk); #1;
    repeat (5) tick();
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", trace_valid, 0); chk("arst_data", trace_data, 0);
    chk("arst_busy", busy, 0);         chk("arst_lap", lap_count, 0);
    chk("arst_in_loop", in_loop, 0);   chk("arst_loop_start", loop_start, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    repeat (4) tick();
    @(negedge clk);
    chk("post_rst_busy", busy, 0); chk("post_rst_valid", trace_valid, 0);

    // Randomized playback with backpressure and ignored noise on start/wr_en
    @(posedge clk); #1;
    for (int t = 0; t < 30; t++) begin
      halt();
      for (int a = 0; a < DEPTH; a++) wr(a, $urandom_range(0, 127));
      go($urandom_range(0, 9), $urandom_range(0, 9));
      for (int c = 0; c < int'($urandom_range(10, 60)); c++) begin
        trace_ready = 1'($urandom_range(0, 1));
        start       = ($urandom_range(0, 7) == 0);
        prefix_len  = (AW+1)'($urandom_range(0, 9));
        loop_len    = (AW+1)'($urandom_range(0, 9));
        wr_en       = ($urandom_range(0, 7) == 0);
        wr_addr     = AW'($urandom_range(0, DEPTH - 1));
        wr_data     = WIDTH'($urandom_range(0, 127));
        stop        = ($urandom_range(0, 39) == 0);
        tick();
      end
      start = 1'b0; wr_en = 1'b0; stop = 1'b0;
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lasso_trace_player.md
# lasso_trace_player

Replays a stored lasso-shaped trace (a finite prefix followed by an endlessly repeated loop) as a stream of state vectors. It is the generating end of our liveness-to-safety checking flow. The monitor side detects a loop and closes it with shadow registers. This block produces such a loop deterministically, so monitors can be driven with known lasso witnesses in simulation and in formal. It sits between a trace-loading source (bench or config logic) and the monitor or design under check.

## Interface
Parameters:
- WIDTH, 7: bits per trace entry (default packs counter[3:0], q, x, y).
- DEPTH, 16: trace memory entries; must be a power of two ≥ 2.
- AW, $clog2(DEPTH): address width; derived, do not override.

Ports:
- clk  in  1  the single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write one trace entry this cycle; honoured only in IDLE.
- wr_addr  in  AW  entry index to write.
- wr_data  in  WIDTH  entry value.
- prefix_len  in  AW+1  number of prefix entries; sampled on start.
- loop_len  in  AW+1  number of loop entries; sampled on start.
- start  in  1  begin playback; honoured only in IDLE.
- stop  in  1  synchronous abort to IDLE; overrides every other input.
- trace_ready  in  1  consumer accepts the current entry.
- trace_valid  out  1  trace_data holds a valid entry.
- trace_data  out  WIDTH  current entry.
- loop_start  out  1  current entry is the first loop entry on the first lap.
- in_loop  out  1  current entry belongs to the loop segment.
- lap_count  out  8  completed loop laps, saturating at 255.
- cfg_err  out  1  the last start was rejected; sticky until the next accepted start or reset.
- busy  out  1  state is not IDLE.

## Operation
- Memory: DEPTH×WIDTH register array, write-only from the wr_* port, not reset. Prefix occupies entries 0..prefix_len-1. Loop occupies entries prefix_len..prefix_len+loop_len-1.
- FSM states: IDLE, PREFIX, LOOP.
- IDLE + start:
  - Config is valid when loop_len ≥ 1 and prefix_len+loop_len ≤ DEPTH, computed at AW+2 bits with no overflow.
  - If invalid: set cfg_err, stay in IDLE.
  - If valid: clear cfg_err, latch both lengths, clear lap_count. Go to PREFIX at ptr=0, or to LOOP at ptr=prefix_len if prefix_len=0.
- Transfer: occurs when trace_valid & trace_ready. On a transfer, ptr advances. With no transfer, trace_data, in_loop and loop_start hold stable.
- PREFIX: after a transfer at ptr=prefix_len-1, go to LOOP with ptr=prefix_len.
- LOOP: after a transfer at ptr=prefix_len+loop_len-1, wrap ptr to prefix_len and increment lap_count (saturating). loop_len=1 repeats a single entry every transfer.
- loop_start is 1 only while presenting entry prefix_len in LOOP with lap_count=0. It deasserts after that entry transfers and never reasserts until the next start.
- in_loop equals (state==LOOP).
- Playback never terminates on its own; only stop or reset ends it.
- stop, in any state: next state IDLE, trace_valid=0, lap_count holds its value, cfg_err unchanged. start in the same cycle is ignored.
- wr_en outside IDLE is dropped silently. A write and a start in the same IDLE cycle: the write lands, and playback reads the new value.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; trace_valid=0, trace_data=0, loop_start=0, in_loop=0, lap_count=0, cfg_err=0, busy=0. Memory contents are undefined.
- trace_data, trace_valid, in_loop and loop_start are registered.
- First entry: start accepted at edge N → trace_valid=1 with the first entry after edge N+1 (one-cycle latency).
- With trace_ready held high: one entry per cycle, no bubbles, including across the prefix→loop boundary and on wrap.
- busy=1 from the edge that accepts start until the edge that applies stop.
- Reset asserted mid-playback: immediate return to reset values.
- The loaded trace is retained across stop, so a second start replays it.

## Test plan
- Load entries 0..5 = 0x10..0x15; prefix_len=2, loop_len=4; trace_ready=1 → sequence 10,11,12,13,14,15,12,13,…
  - loop_start high only on the first 0x12.
  - lap_count=1 after the first 0x15 transfers.
- Same trace with trace_ready toggling 1,0,0,1 → trace_data stable while ready=0; sequence unchanged; no entry skipped or duplicated.
- prefix_len=0, loop_len=1, entry 0=0x7F → first output 0x7F with loop_start=1 and in_loop=1; thereafter constant 0x7F; lap_count saturates at 255 after 255 transfers.
- Rejected starts:
  - loop_len=0 → cfg_err=1, busy stays 0.
  - prefix_len=10, loop_len=7 with DEPTH=16 → cfg_err=1, busy stays 0.
  - A following valid start clears cfg_err.
- stop asserted mid-loop together with start and wr_en → IDLE next cycle, trace_valid=0, write dropped; a restart replays from entry 0 with loop_start again.
- rst driven low between edges during LOOP → all outputs at reset values before the next edge; playback resumes only on a new start.
